// File: rtl/cpu_step_if.sv
// cpu_step_if: button/halt inputs and enable/status outputs of the run/step controller.
// master = the side driving buttons and halt (board/test), slave = cpu_step_ctrl.
interface cpu_step_if #(
   parameter int CNT_W = 16
);
   logic             btn_step;
   logic             btn_mode;
   logic             halt_req;
   logic             cpu_en;
   logic             running;
   logic             stopped;
   logic [CNT_W-1:0] step_cnt;

   modport master (
      output btn_step, btn_mode, halt_req,
      input  cpu_en, running, stopped, step_cnt
   );

   modport slave (
      input  btn_step, btn_mode, halt_req,
      output cpu_en, running, stopped, step_cnt
   );
endinterface

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/single-step controller producing the CPU clock-enable.
// Each button level change is one press. A step press issues a burst of STEP_BURST
// enable cycles; the mode button toggles a divided continuous run. halt_req parks the
// controller in S_STOP until the next mode press.
// Optional feature: define STEP_CTRL_AUTOCLR_EN to clear step_cnt on leaving S_STOP.
module cpu_step_ctrl #(
   parameter int RUN_DIV    = 4,
   parameter int STEP_BURST = 1,
   parameter int CNT_W      = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   cpu_step_if.slave bus
);

   localparam int DIV_W   = (RUN_DIV    > 1) ? $clog2(RUN_DIV)    : 1;
   localparam int BURST_W = (STEP_BURST > 1) ? $clog2(STEP_BURST) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(RUN_DIV - 1);
   localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(STEP_BURST - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN, S_STOP} state_t;

   state_t             state_q, state_d;
   logic [2:0]         step_sync_q, mode_sync_q;  // [0]=s1, [1]=s2, [2]=history s3
   logic [1:0]         arm_q;
   logic               step_evt_q, mode_evt_q;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BURST_W-1:0] burst_q, burst_d;           // enable cycles left after the current one
   logic               cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               armed;

   // Arm guard: the sync chain fills for three edges after reset before any press counts,
   // so a button already at 1 through reset release does not look like a press.
   assign armed = (arm_q == 2'd3);

   // Button synchronisers, arm counter and registered press events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_sync_q <= '0;
         mode_sync_q <= '0;
         arm_q       <= '0;
         step_evt_q  <= 1'b0;
         mode_evt_q  <= 1'b0;
      end else begin
         step_sync_q <= {step_sync_q[1:0], bus.btn_step};
         mode_sync_q <= {mode_sync_q[1:0], bus.btn_mode};
         if (!armed) arm_q <= arm_q + 2'd1;
         step_evt_q  <= armed & (step_sync_q[1] ^ step_sync_q[2]);
         mode_evt_q  <= armed & (mode_sync_q[1] ^ mode_sync_q[2]);
      end
   end

   // State register plus registered enable, divider, burst counter and step count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_HALT;
         div_q    <= '0;
         burst_q  <= '0;
         cpu_en_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         burst_q  <= burst_d;
         cpu_en_q <= cpu_en_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic; the divider restarts from 0 whenever the FSM is not staying in S_RUN
   always_comb begin
      state_d = state_q;
      div_d   = '0;
      burst_d = burst_q;
      case (state_q)
         S_HALT: begin
            if (mode_evt_q) begin
               state_d = S_RUN;                // mode wins over a simultaneous step
            end else if (step_evt_q) begin
               state_d = S_STEP;
               burst_d = BURST_LOAD;
            end
         end
         S_STEP: begin
            if (bus.halt_req)        state_d = S_STOP;
            else if (burst_q == '0)  state_d = S_HALT;
            else                     burst_d = burst_q - 1'b1;
         end
         S_RUN: begin
            if (bus.halt_req)        state_d = S_STOP;   // halt beats a mode press
            else if (mode_evt_q)     state_d = S_HALT;
            else                     div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         end
         S_STOP: begin
            if (mode_evt_q)          state_d = S_HALT;
         end
         default:                    state_d = S_HALT;
      endcase
   end

   // Output logic: status decode, next enable and saturating step count
   always_comb begin
      bus.running = (state_q == S_RUN);
      bus.stopped = (state_q == S_STOP);
      bus.cpu_en  = cpu_en_q;
      bus.step_cnt = cnt_q;
      // Run pulse fires on the edge after the divider reaches its last value, so the
      // first pulse lands RUN_DIV edges after entry.
      cpu_en_d = (state_d == S_STEP) ||
                 ((state_q == S_RUN) && (state_d == S_RUN) && (div_q == DIV_LAST));
      cnt_d = cnt_q;
      if (cpu_en_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
`ifdef STEP_CTRL_AUTOCLR_EN
      if ((state_q == S_STOP) && (state_d == S_HALT)) cnt_d = '0;
`else
      // step_cnt survives leaving S_STOP; only rst_n clears it
`endif
   end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed scenarios with literal expectations followed by random
// button/halt/reset traffic, all compared every cycle against a behavioural model.
module tb_cpu_step_ctrl;
   localparam int RUN_DIV    = 4;
   localparam int STEP_BURST = 3;
   localparam int CNT_W      = 4;
   localparam int CMAX       = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   cpu_step_if #(.CNT_W(CNT_W)) bus ();

   cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .STEP_BURST(STEP_BURST), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A press is any change of the sampled button level; the controller reacts to the
   // change seen between samples k-4 and k-3 at edge k, and only from edge 4 after release.
   localparam int MH = 0, MS = 1, MR = 2, MX = 3;  // halt, step, run, stop
   bit hs[0:4];
   bit hm[0:4];
   int m_k = 0, m_st = MH, m_since = 0, m_left = 0, m_cnt = 0;
   bit m_en = 0;

   always @(posedge clk or negedge rst_n) begin
      bit sev, mev;
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin hs[i] = 0; hm[i] = 0; end
         m_k = 0; m_st = MH; m_since = 0; m_left = 0; m_cnt = 0; m_en = 0;
      end else begin
         for (int i = 4; i > 0; i--) begin hs[i] = hs[i-1]; hm[i] = hm[i-1]; end
         hs[0] = bus.btn_step;
         hm[0] = bus.btn_mode;
         sev = (m_k >= 4) && (hs[3] != hs[4]);
         mev = (m_k >= 4) && (hm[3] != hm[4]);
         case (m_st)
            MH: if (mev) begin m_st = MR; m_since = 0; end
                else if (sev) begin m_st = MS; m_left = STEP_BURST; end
            MS: if (bus.halt_req) m_st = MX;
                else begin m_left--; if (m_left == 0) m_st = MH; end
            MR: if (bus.halt_req) m_st = MX;
                else if (mev) m_st = MH;
                else m_since++;
            default: if (mev) begin
                        m_st = MH;
`ifdef STEP_CTRL_AUTOCLR_EN
                        m_cnt = 0;
`endif
                     end
         endcase
         m_en = (m_st == MS) || (m_st == MR && m_since > 0 && (m_since % RUN_DIV) == 0);
         if (m_en && m_cnt < CMAX) m_cnt++;
         m_k++;
      end
   end

   // Single compare process, sampling away from the active edge
   always @(negedge clk) begin
      chk("cpu_en",   int'(bus.cpu_en),   int'(m_en));
      chk("running",  int'(bus.running),  int'(m_st == MR));
      chk("stopped",  int'(bus.stopped),  int'(m_st == MX));
      chk("step_cnt", int'(bus.step_cnt), m_cnt);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic count_en(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin cyc(); pulses += int'(bus.cpu_en); end
   endtask

   int p;
   int cnt_before;

   initial begin
      bus.btn_step = 0; bus.btn_mode = 0; bus.halt_req = 0;
      #1 rst_n = 0;
      cyc(2);
      chk("reset cpu_en", int'(bus.cpu_en), 0);
      chk("reset step_cnt", int'(bus.step_cnt), 0);
      rst_n = 1;
      cyc(6);

      // single step press: STEP_BURST enable cycles, back to halt
      bus.btn_step = ~bus.btn_step;
      cyc(3);
      chk("step latency pre", int'(bus.cpu_en), 0);
      cyc();
      chk("step first en", int'(bus.cpu_en), 1);
      count_en(8, p);
      chk("step burst len", p + 1, 3);
      chk("step cnt", int'(bus.step_cnt), 3);
      chk("step back halt", int'(bus.running | bus.stopped), 0);

      // run mode: 5 pulses in 20 cycles, then back to halt
      bus.btn_mode = ~bus.btn_mode;
      cyc(4);
      chk("run entered", int'(bus.running), 1);
      count_en(20, p);
      chk("run pulses", p, 5);
      chk("run cnt", int'(bus.step_cnt), 8);
      bus.btn_mode = ~bus.btn_mode;
      cyc(4);
      chk("run exit", int'(bus.running), 0);

      // halt_req in run -> stop; step ignored; mode exits
      bus.btn_mode = ~bus.btn_mode;
      cyc(6);
      bus.halt_req = 1;
      cyc();
      bus.halt_req = 0;
      chk("stop entered", int'(bus.stopped), 1);
      chk("stop en low", int'(bus.cpu_en), 0);
      cnt_before = int'(bus.step_cnt);
      bus.btn_step = ~bus.btn_step;
      cyc(6);
      chk("stop ignores step", int'(bus.stopped), 1);
      chk("stop cnt hold", int'(bus.step_cnt), cnt_before);
      bus.btn_mode = ~bus.btn_mode;
      cyc(4);
      chk("stop exit", int'(bus.stopped | bus.running), 0);
`ifdef STEP_CTRL_AUTOCLR_EN
      chk("stop exit cnt", int'(bus.step_cnt), 0);
`else
      chk("stop exit cnt", int'(bus.step_cnt), cnt_before);
`endif

      // simultaneous step+mode in halt: run, no burst
      bus.btn_step = ~bus.btn_step;
      bus.btn_mode = ~bus.btn_mode;
      cyc(4);
      chk("both run", int'(bus.running), 1);
      count_en(3, p);
      chk("both no burst", p, 0);
      bus.btn_mode = ~bus.btn_mode;
      cyc(8);

      // reset during second burst cycle
      bus.btn_step = ~bus.btn_step;
      cyc(4);
      chk("burst c1", int'(bus.cpu_en), 1);
      cyc();
      chk("burst c2", int'(bus.cpu_en), 1);
      rst_n = 0;
      #1;
      chk("midreset en", int'(bus.cpu_en), 0);
      chk("midreset cnt", int'(bus.step_cnt), 0);
      chk("midreset st", int'(bus.running | bus.stopped), 0);

      // btn_step held at 1 through release: no press
      bus.btn_step = 1;
      cyc(2);
      rst_n = 1;
      count_en(10, p);
      chk("held btn no en", p, 0);

      // saturation: 6 presses x 3 cycles > 15
      for (int i = 0; i < 6; i++) begin
         bus.btn_step = ~bus.btn_step;
         cyc(8);
      end
      chk("cnt saturate", int'(bus.step_cnt), 15);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0)  bus.btn_step = ~bus.btn_step;
         if ($urandom_range(0, 13) == 0) bus.btn_mode = ~bus.btn_mode;
         bus.halt_req = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 699) == 0) begin
            rst_n = 0;
            cyc($urandom_range(1, 2));
            rst_n = 1;
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
